rv_fetch_unit: RTL

Instruction fetch front end that produces the instruction stream consumed by the pipelined RV32I core's decode stage. It generates sequential PCs, issues word requests to instruction memory over a valid/ready request channel, and buffers in-order responses in a small prefetch FIFO. It presents one instruction per cycle to the core with a valid/ready handshake, and flushes on a branch/jump redirect from execute.

---
 rtl/rv_pkg.sv | 29 ++
 rtl/rv_fetch_fifo.sv | 59 +++++
 rtl/rv_fetch_unit.sv | 110 +++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I definitions: datapath width, NOP encoding, major opcodes and
// the fetch-buffer entry layout.
package rv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OP_IMM = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111
  } opcode_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] word;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] next_word(input logic [XLEN-1:0] addr);
    return addr + XLEN'(4);
  endfunction

endpackage

// File: rtl/rv_fetch_fifo.sv
// Register-based prefetch FIFO with combinational head; flush beats push/pop.
module rv_fetch_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic [WIDTH-1:0]           head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; occupancy is tracked by count_reg alone.
  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= din;
  end

  assign head  = mem_reg[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/rv_fetch_unit.sv
// RV32I fetch front end: credit-limited sequential requests, in-order response
// buffering, and redirect flush with discard of in-flight stale words.
module rv_fetch_unit
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] instr_pc
);

  localparam int CW = $clog2(FIFO_DEPTH+1);

  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] rsp_pc_reg, rsp_pc_next;
  logic [CW-1:0]   outstanding_reg, outstanding_next;
  logic [CW-1:0]   discard_reg, discard_next;
  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  logic            fifo_full;
  fetch_entry_t    fifo_head;
  fetch_entry_t    fifo_din;
  logic [CW:0]     credit_used;
  logic            req_fire;
  logic            rsp_accept;
  logic            fifo_push;
  logic            fifo_pop;
  logic            unused_bits;

  // Buffered plus in-flight words may never exceed the FIFO, so a response
  // always finds room without backpressuring memory.
  assign credit_used    = {1'b0, fifo_count} + {1'b0, outstanding_reg};
  assign imem_req_valid = rst_n && !redirect_valid
                          && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = pc_reg;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_accept = imem_rsp_valid && (outstanding_reg != '0);
  assign fifo_push  = rsp_accept && (discard_reg == '0) && !redirect_valid;
  assign fifo_pop   = instr_valid && instr_ready;
  assign fifo_din   = '{pc: rsp_pc_reg, word: imem_rsp_data};

  always_comb begin
    pc_next          = pc_reg;
    rsp_pc_next      = rsp_pc_reg;
    discard_next     = discard_reg;
    outstanding_next = outstanding_reg + CW'(req_fire) - CW'(rsp_accept);
    if (req_fire) pc_next = next_word(pc_reg);
    if (rsp_accept) begin
      if (discard_reg != '0) discard_next = discard_reg - CW'(1);
      else                   rsp_pc_next  = next_word(rsp_pc_reg);
    end
    // Every request still in flight after this cycle's response is stale.
    if (redirect_valid) begin
      pc_next      = {redirect_pc[XLEN-1:2], 2'b00};
      rsp_pc_next  = {redirect_pc[XLEN-1:2], 2'b00};
      discard_next = outstanding_reg - CW'(rsp_accept);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg          <= RESET_PC;
      rsp_pc_reg      <= RESET_PC;
      outstanding_reg <= '0;
      discard_reg     <= '0;
    end else begin
      pc_reg          <= pc_next;
      rsp_pc_reg      <= rsp_pc_next;
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;
    end
  end

  rv_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .flush (redirect_valid),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full),
    .head  (fifo_head)
  );

  assign instr_valid = !fifo_empty;
  assign instruction = fifo_empty ? NOP_INSTR : fifo_head.word;
  assign instr_pc    = fifo_empty ? '0 : fifo_head.pc;

  assign unused_bits = ^{redirect_pc[1:0], fifo_full};

endmodule
